sal_sched_rr: RTL and testbench

// Parametrised successor of the fixed-priority DRAM command scheduler; sits between the per-bank controllers and the timing/PHY stage.

---
 rtl/sal_sched_pkg.sv | 48 ++++
 rtl/sal_rr_arb.sv | 41 ++++
 rtl/sal_sched_rr.sv | 245 ++++++++++++++++++++++++
 tb/tb_sal_sched_rr.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sal_sched_pkg.sv
`default_nettype none
// ============================================================================
// sal_sched_pkg : shared types for the round-robin DRAM command scheduler
// Rev 1.0
// ============================================================================
package sal_sched_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_t;

    typedef enum logic {
        RD_MODE = 1'b0,
        WR_MODE = 1'b1
    } mode_t;

    typedef struct packed {
        logic valid;
        cmd_t typ;
    } slot_hdr_t;

    localparam int NUM_CLS = 5;

    // Class indices double as the arbiter instance numbers
    localparam logic [2:0] CLS_ACT = 3'd0;
    localparam logic [2:0] CLS_RD  = 3'd1;
    localparam logic [2:0] CLS_WR  = 3'd2;
    localparam logic [2:0] CLS_PRE = 3'd3;
    localparam logic [2:0] CLS_REF = 3'd4;

    function automatic cmd_t cls_to_cmd(input logic [2:0] cls);
        case (cls)
            CLS_ACT: return CMD_ACT;
            CLS_RD:  return CMD_RD;
            CLS_WR:  return CMD_WR;
            CLS_PRE: return CMD_PRE;
            CLS_REF: return CMD_REF;
            default: return CMD_NOP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sal_rr_arb.sv
`default_nettype none
// ============================================================================
// sal_rr_arb : round-robin pick of the first requester at/after a pointer
// Rev 1.0
// ============================================================================
module sal_rr_arb #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        sum   = '0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_i} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            k = sum[IW-1:0];
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                idx_o    = k;
                gnt_o[k] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sal_sched_rr.sv
`default_nettype none
// ============================================================================
// sal_sched_rr : per-class round-robin DRAM command scheduler with R/W
//                batching, starvation promotion and a registered output slot
// Rev 1.0
// ============================================================================
module sal_sched_rr
    import sal_sched_pkg::*;
#(
    parameter  int BK_CNT       = 4,
    parameter  int RA_W         = 16,
    parameter  int CA_W         = 10,
    parameter  int ID_W         = 4,
    parameter  int LEN_W        = 4,
    parameter  int WR_BATCH     = 4,
    parameter  int STARVE_LIMIT = 16,
    localparam int BA_W         = $clog2(BK_CNT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BK_CNT-1:0]            act_req_i,
    input  logic [BK_CNT-1:0]            rd_req_i,
    input  logic [BK_CNT-1:0]            wr_req_i,
    input  logic [BK_CNT-1:0]            pre_req_i,
    input  logic [BK_CNT-1:0]            ref_req_i,
    input  logic                         ref_urgent_i,
    input  logic [BK_CNT-1:0][RA_W-1:0]  bk_ra_i,
    input  logic [BK_CNT-1:0][CA_W-1:0]  bk_ca_i,
    input  logic [BK_CNT-1:0][ID_W-1:0]  bk_id_i,
    input  logic [BK_CNT-1:0][LEN_W-1:0] bk_len_i,
    output logic [BK_CNT-1:0]            act_gnt_o,
    output logic [BK_CNT-1:0]            rd_gnt_o,
    output logic [BK_CNT-1:0]            wr_gnt_o,
    output logic [BK_CNT-1:0]            pre_gnt_o,
    output logic [BK_CNT-1:0]            ref_gnt_o,
    output logic                         cmd_valid_o,
    input  logic                         cmd_ready_i,
    output cmd_t                         cmd_type_o,
    output logic [BA_W-1:0]              cmd_ba_o,
    output logic [RA_W-1:0]              cmd_ra_o,
    output logic [CA_W-1:0]              cmd_ca_o,
    output logic [ID_W-1:0]              cmd_id_o,
    output logic [LEN_W-1:0]             cmd_len_o
);

    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam int BT_W  = $clog2(WR_BATCH + 1);

    logic [NUM_CLS-1:0][BK_CNT-1:0] cls_req;
    logic [NUM_CLS-1:0][BK_CNT-1:0] arb_gnt;
    logic [NUM_CLS-1:0][BA_W-1:0]   arb_idx;
    logic [NUM_CLS-1:0]             arb_any;
    logic [BK_CNT-1:0]              bk_any;

    logic [NUM_CLS-1:0][BA_W-1:0]   ptr_q, ptr_d;
    logic [BK_CNT-1:0][AGE_W-1:0]   age_q, age_d;
    mode_t                          mode_q, mode_d;
    logic [BT_W-1:0]                batch_q, batch_d, batch_nx;

    slot_hdr_t                      hdr_q, hdr_d;
    logic [BA_W-1:0]                ba_q, ba_d;
    logic [RA_W-1:0]                ra_q, ra_d;
    logic [CA_W-1:0]                ca_q, ca_d;
    logic [ID_W-1:0]                id_q, id_d;
    logic [LEN_W-1:0]               len_q, len_d;

    logic                           slot_free;
    logic                           st_hit;
    logic [BA_W-1:0]                st_bk;
    logic [2:0]                     st_cls;
    logic                           cas_wr;
    logic                           win_vld;
    logic                           win_st;
    logic [2:0]                     win_cls;
    logic [BA_W-1:0]                win_bk;
    logic [BK_CNT-1:0]              win_oh;
    logic                           win_cas;

    assign cls_req[CLS_ACT] = act_req_i;
    assign cls_req[CLS_RD]  = rd_req_i;
    assign cls_req[CLS_WR]  = wr_req_i;
    assign cls_req[CLS_PRE] = pre_req_i;
    assign cls_req[CLS_REF] = ref_req_i;
    assign bk_any    = act_req_i | rd_req_i | wr_req_i | pre_req_i | ref_req_i;
    assign slot_free = !hdr_q.valid || cmd_ready_i;

    for (genvar c = 0; c < NUM_CLS; c++) begin : g_arb
        sal_rr_arb #(.N(BK_CNT)) u_arb (
            .req_i (cls_req[c]),
            .ptr_i (ptr_q[c]),
            .gnt_o (arb_gnt[c]),
            .idx_o (arb_idx[c]),
            .any_o (arb_any[c])
        );
    end

    always_comb begin
        // Lowest-index starved bank; its highest-priority pending request class
        st_hit = 1'b0;
        st_bk  = '0;
        for (int b = BK_CNT - 1; b >= 0; b--) begin
            if (age_q[b] == AGE_W'(STARVE_LIMIT) && bk_any[b]) begin
                st_hit = 1'b1;
                st_bk  = BA_W'(b);
            end
        end
        st_cls = CLS_REF;
        for (int c = NUM_CLS - 1; c >= 0; c--) begin
            if (cls_req[c][st_bk]) begin
                st_cls = 3'(c);
            end
        end

        cas_wr = (mode_q == RD_MODE) ? (!arb_any[CLS_RD] && arb_any[CLS_WR])
                                     : arb_any[CLS_WR];

        win_vld = 1'b0;
        win_st  = 1'b0;
        win_cls = CLS_ACT;
        if (slot_free && !rst) begin
            win_vld = 1'b1;
            if (ref_urgent_i && arb_any[CLS_REF]) begin
                win_cls = CLS_REF;
            end else if (st_hit) begin
                win_st  = 1'b1;
                win_cls = st_cls;
            end else if (arb_any[CLS_ACT]) begin
                win_cls = CLS_ACT;
            end else if (cas_wr) begin
                win_cls = CLS_WR;
            end else if (arb_any[CLS_RD]) begin
                win_cls = CLS_RD;
            end else if (arb_any[CLS_PRE]) begin
                win_cls = CLS_PRE;
            end else if (arb_any[CLS_REF]) begin
                win_cls = CLS_REF;
            end else begin
                win_vld = 1'b0;
            end
        end

        win_bk = '0;
        win_oh = '0;
        if (win_vld) begin
            if (win_st) begin
                win_bk = st_bk;
                win_oh = BK_CNT'(1) << st_bk;
            end else begin
                win_bk = arb_idx[win_cls];
                win_oh = arb_gnt[win_cls];
            end
        end
        win_cas = win_vld && (win_cls == CLS_RD || win_cls == CLS_WR);

        ptr_d = ptr_q;
        if (win_vld) begin
            ptr_d[win_cls] = (win_bk == BA_W'(BK_CNT - 1)) ? '0 : win_bk + 1'b1;
        end

        // CAS batching: a write batch ends at WR_BATCH grants or on any read grant
        mode_d   = mode_q;
        batch_d  = batch_q;
        batch_nx = ((mode_q == WR_MODE) ? batch_q : '0) + 1'b1;
        if (win_vld && win_cls == CLS_RD) begin
            mode_d  = RD_MODE;
            batch_d = '0;
        end else if (win_vld && win_cls == CLS_WR) begin
            if (batch_nx == BT_W'(WR_BATCH)) begin
                mode_d  = RD_MODE;
                batch_d = '0;
            end else begin
                mode_d  = WR_MODE;
                batch_d = batch_nx;
            end
        end

        for (int b = 0; b < BK_CNT; b++) begin
            if (!bk_any[b] || win_oh[b]) begin
                age_d[b] = '0;
            end else if (age_q[b] != AGE_W'(STARVE_LIMIT)) begin
                age_d[b] = age_q[b] + 1'b1;
            end else begin
                age_d[b] = age_q[b];
            end
        end

        hdr_d = hdr_q;
        ba_d  = ba_q;
        ra_d  = ra_q;
        ca_d  = ca_q;
        id_d  = id_q;
        len_d = len_q;
        if (slot_free) begin
            hdr_d.valid = win_vld;
            hdr_d.typ   = win_vld ? cls_to_cmd(win_cls) : CMD_NOP;
            ba_d        = win_bk;
            ra_d        = (win_vld && win_cls == CLS_ACT) ? bk_ra_i[win_bk] : '0;
            ca_d        = win_cas ? bk_ca_i[win_bk]  : '0;
            id_d        = win_cas ? bk_id_i[win_bk]  : '0;
            len_d       = win_cas ? bk_len_i[win_bk] : '0;
        end
    end

    assign act_gnt_o = (win_vld && win_cls == CLS_ACT) ? win_oh : '0;
    assign rd_gnt_o  = (win_vld && win_cls == CLS_RD)  ? win_oh : '0;
    assign wr_gnt_o  = (win_vld && win_cls == CLS_WR)  ? win_oh : '0;
    assign pre_gnt_o = (win_vld && win_cls == CLS_PRE) ? win_oh : '0;
    assign ref_gnt_o = (win_vld && win_cls == CLS_REF) ? win_oh : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            age_q   <= '0;
            mode_q  <= RD_MODE;
            batch_q <= '0;
            hdr_q   <= '{valid: 1'b0, typ: CMD_NOP};
            ba_q    <= '0;
            ra_q    <= '0;
            ca_q    <= '0;
            id_q    <= '0;
            len_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            age_q   <= age_d;
            mode_q  <= mode_d;
            batch_q <= batch_d;
            hdr_q   <= hdr_d;
            ba_q    <= ba_d;
            ra_q    <= ra_d;
            ca_q    <= ca_d;
            id_q    <= id_d;
            len_q   <= len_d;
        end
    end

    assign cmd_valid_o = hdr_q.valid;
    assign cmd_type_o  = hdr_q.typ;
    assign cmd_ba_o    = ba_q;
    assign cmd_ra_o    = ra_q;
    assign cmd_ca_o    = ca_q;
    assign cmd_id_o    = id_q;
    assign cmd_len_o   = len_q;

endmodule
`default_nettype wire

// File: tb/tb_sal_sched_rr.sv
`default_nettype none
// ============================================================================
// tb_sal_sched_rr : directed self-checking bench for sal_sched_rr
// Rev 1.0
// ============================================================================
module tb_sal_sched_rr;
    import sal_sched_pkg::*;

    localparam int BK = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [BK-1:0]        act_req, rd_req, wr_req, pre_req, ref_req;
    logic                 ref_urgent;
    logic [BK-1:0][15:0]  bk_ra;
    logic [BK-1:0][9:0]   bk_ca;
    logic [BK-1:0][3:0]   bk_id;
    logic [BK-1:0][3:0]   bk_len;
    logic [BK-1:0]        act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic                 cmd_valid, cmd_ready;
    cmd_t                 cmd_type;
    logic [1:0]           cmd_ba;
    logic [15:0]          cmd_ra;
    logic [9:0]           cmd_ca;
    logic [3:0]           cmd_id, cmd_len;

    int n_chk = 0;
    int n_err = 0;

    sal_sched_rr #(
        .BK_CNT(BK), .RA_W(16), .CA_W(10), .ID_W(4), .LEN_W(4),
        .WR_BATCH(4), .STARVE_LIMIT(8)
    ) u_dut (
        .clk(clk), .rst(rst),
        .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req),
        .pre_req_i(pre_req), .ref_req_i(ref_req), .ref_urgent_i(ref_urgent),
        .bk_ra_i(bk_ra), .bk_ca_i(bk_ca), .bk_id_i(bk_id), .bk_len_i(bk_len),
        .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt),
        .pre_gnt_o(pre_gnt), .ref_gnt_o(ref_gnt),
        .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
        .cmd_type_o(cmd_type), .cmd_ba_o(cmd_ba), .cmd_ra_o(cmd_ra),
        .cmd_ca_o(cmd_ca), .cmd_id_o(cmd_id), .cmd_len_o(cmd_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
        ref_urgent = 1'b0;
        cmd_ready  = 1'b0;
        for (int b = 0; b < BK; b++) begin
            bk_ra[b]  = 16'h1000 + 16'(b);
            bk_ca[b]  = 10'h100 + 10'(b);
            bk_id[b]  = 4'(b + 5);
            bk_len[b] = 4'(b + 1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [3:0] exp_rd [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] exp_wr [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        // Reset values, then asynchronous reset with a full slot
        rst = 1'b1;
        clear_inputs();
        tick();
        check("rst_valid", cmd_valid, 0);
        check("rst_type",  cmd_type, CMD_NOP);
        check("rst_fields", {cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len}, 0);
        rst = 1'b0;
        act_req   = 4'b0001;
        bk_ra[0]  = 16'h1234;
        #1 check("t1_act_gnt", act_gnt, 4'b0001);
        tick();
        check("t1_slot_valid", cmd_valid, 1);
        check("t1_slot_type",  cmd_type, CMD_ACT);
        check("t1_slot_ra",    cmd_ra, 16'h1234);
        #2 rst = 1'b1;
        #1;
        check("t1_async_valid", cmd_valid, 0);
        check("t1_async_type",  cmd_type, CMD_NOP);
        check("t1_async_gnts",  act_gnt | rd_gnt | wr_gnt | pre_gnt | ref_gnt, 0);
        check("t1_async_ra",    cmd_ra, 0);

        // Read round-robin with ready held high
        do_reset();
        cmd_ready = 1'b1;
        rd_req    = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1 check("t2_rd_gnt", rd_gnt, exp_rd[i]);
            tick();
            check("t2_type", cmd_type, CMD_RD);
            check("t2_ba",   cmd_ba, 32'(i % 4));
            check("t2_ca",   cmd_ca, 32'(10'h100 + 10'(i % 4)));
            check("t2_ra",   cmd_ra, 0);
        end

        // Backpressure holds the slot
        do_reset();
        act_req  = 4'b0100;
        bk_ra[2] = 16'hABCD;
        #1 check("t3_act_gnt", act_gnt, 4'b0100);
        tick();
        act_req = '0;
        pre_req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_hold_valid", cmd_valid, 1);
            check("t3_hold_type",  cmd_type, CMD_ACT);
            check("t3_hold_ba",    cmd_ba, 2);
            check("t3_hold_ra",    cmd_ra, 16'hABCD);
            check("t3_no_gnt",     pre_gnt | act_gnt, 0);
            tick();
        end
        cmd_ready = 1'b1;
        #1 check("t3_release_gnt", pre_gnt, 4'b0010);
        tick();
        check("t3_pre_type", cmd_type, CMD_PRE);
        check("t3_pre_ba",   cmd_ba, 1);
        check("t3_pre_ra",   cmd_ra, 0);

        // Write batch of four, then the waiting read
        do_reset();
        cmd_ready = 1'b1;
        wr_req    = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t4_wr_gnt", wr_gnt, exp_wr[i]);
            check("t4_rd_gnt", rd_gnt, 0);
            tick();
            check("t4_wr_type", cmd_type, CMD_WR);
            check("t4_wr_ba",   cmd_ba, 32'(i));
            if (i == 1) rd_req = 4'b0010;
        end
        #1;
        check("t4_rd_after_batch", rd_gnt, 4'b0010);
        check("t4_wr_blocked",     wr_gnt, 0);
        tick();
        check("t4_rd_type", cmd_type, CMD_RD);
        check("t4_rd_ba",   cmd_ba, 1);
        check("t4_rd_id",   cmd_id, 6);
        check("t4_rd_len",  cmd_len, 2);

        // Starvation promotion of a PRE behind continuous ACTs
        do_reset();
        cmd_ready = 1'b1;
        act_req   = 4'b0010;
        pre_req   = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("t5_act_gnt", act_gnt, (i == 8) ? 4'b0000 : 4'b0010);
            check("t5_pre_gnt", pre_gnt, (i == 8) ? 4'b0100 : 4'b0000);
            tick();
            if (i == 8) begin
                check("t5_pre_type", cmd_type, CMD_PRE);
                check("t5_pre_ba",   cmd_ba, 2);
            end
        end

        // Urgent refresh beats ACT; without a ref request it has no effect
        do_reset();
        cmd_ready  = 1'b1;
        ref_urgent = 1'b1;
        ref_req    = 4'b1000;
        act_req    = 4'b0001;
        #1;
        check("t6_ref_gnt", ref_gnt, 4'b1000);
        check("t6_act_wait", act_gnt, 0);
        tick();
        ref_req = '0;
        check("t6_ref_type", cmd_type, CMD_REF);
        check("t6_ref_ba",   cmd_ba, 3);
        #1;
        check("t6_act_gnt", act_gnt, 4'b0001);
        check("t6_ref_none", ref_gnt, 0);
        tick();
        check("t6_act_type", cmd_type, CMD_ACT);
        check("t6_act_ra",   cmd_ra, 16'h1000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
